// File: rtl/reel_spin_engine.sv
// Three-reel slot spin engine: starts on entry into RUN, animates reels from a
// free-running LFSR, freezes them in a staggered order and reports done/win.
module reel_spin_engine #(
  parameter int          SYM_W       = 3,
  parameter int          SPIN_DIV    = 4,
  parameter int          SPIN_CYCLES = 2000,
  parameter int          STOP_GAP    = 500,
  parameter int          CNT_W       = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       state_i,
  output logic [SYM_W-1:0] reel0_o,
  output logic [SYM_W-1:0] reel1_o,
  output logic [SYM_W-1:0] reel2_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             win_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SPIN = 2'b01,
    S_DONE = 2'b10
  } fsm_t;

  localparam logic [1:0]       MC_RUN   = 2'b10;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SPIN_DIV - 1);

  function automatic logic [CNT_W-1:0] frz_at(input int k);
    return CNT_W'(SPIN_CYCLES + k * STOP_GAP);
  endfunction

  function automatic logic [SYM_W-1:0] reel_step(input logic [SYM_W-1:0] r);
    return r + SYM_W'(1);
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  fsm_t             state_q, state_d;
  logic [15:0]      lfsr;
  logic             run_q;
  logic [CNT_W-1:0] spin_cnt;
  logic [CNT_W-1:0] div_cnt;
  logic [SYM_W-1:0] reel_q [3];
  logic [SYM_W-1:0] sym;
  logic             run_now, start, div_wrap, frz_last;
  logic             do_start, do_abort, do_finish;

  assign run_now  = (state_i == MC_RUN);
  assign start    = run_now && !run_q;
  assign sym      = lfsr[SYM_W-1:0];
  assign div_wrap = (div_cnt == DIV_LAST);
  assign frz_last = (spin_cnt == frz_at(2));

  assign reel0_o = reel_q[0];
  assign reel1_o = reel_q[1];
  assign reel2_o = reel_q[2];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    do_start  = 1'b0;
    do_abort  = 1'b0;
    do_finish = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          do_start = 1'b1;
          state_d  = S_SPIN;
        end
      end
      S_SPIN: begin
        // leaving RUN takes priority over a freeze landing on the same edge
        if (!run_now) begin
          do_abort = 1'b1;
          state_d  = S_IDLE;
        end else if (frz_last) begin
          do_finish = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr     <= LFSR_SEED;
      run_q    <= 1'b0;
      spin_cnt <= '0;
      div_cnt  <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      win_o    <= 1'b0;
      for (int k = 0; k < 3; k++) reel_q[k] <= '0;
    end else begin
      lfsr   <= lfsr_step(lfsr);
      run_q  <= run_now;
      done_o <= do_finish;
      if (do_start) begin
        spin_cnt <= '0;
        div_cnt  <= '0;
        busy_o   <= 1'b1;
        win_o    <= 1'b0;
      end else if (do_abort) begin
        busy_o <= 1'b0;
        win_o  <= 1'b0;
      end else if (state_q == S_SPIN) begin
        spin_cnt <= spin_cnt + CNT_W'(1);
        div_cnt  <= div_wrap ? '0 : div_cnt + CNT_W'(1);
        // a reel loads the LFSR symbol on its freeze edge and is inert afterwards
        for (int k = 0; k < 3; k++) begin
          if (spin_cnt == frz_at(k))
            reel_q[k] <= sym;
          else if (spin_cnt < frz_at(k) && div_wrap)
            reel_q[k] <= reel_step(reel_q[k]);
        end
        if (do_finish)
          win_o <= (reel_q[0] == reel_q[1]) && (reel_q[1] == sym);
      end else if (state_q == S_DONE) begin
        busy_o <= 1'b0;
      end
    end
  end

endmodule
